// File: rtl/sfx_tone_mixer.sv
// Multi-channel square-wave sound-effect generator with priority/mute mixing,
// mic passthrough with saturation, and the Audio_Controller read/write handshake.
module sfx_tone_mixer #(
    parameter int NUM_CH    = 4,
    parameter int PERIOD_W  = 19,
    parameter int DUR_W     = 16,
    parameter int SAMPLE_W  = 32,
    parameter int AMPLITUDE = 10000000
) (
    input  logic                         iClock,
    input  logic                         iResetn,
    input  logic [NUM_CH-1:0]            iTrigger,
    input  logic [NUM_CH*PERIOD_W-1:0]   iHalfPeriod,
    input  logic [NUM_CH*DUR_W-1:0]      iDuration,
    input  logic                         iPriorityMode,
    input  logic                         iMute,
    input  logic                         iAudioInAvailable,
    input  logic                         iAudioOutAllowed,
    input  logic [SAMPLE_W-1:0]          iMicLeft,
    input  logic [SAMPLE_W-1:0]          iMicRight,
    output logic                         oReadAudioIn,
    output logic                         oWriteAudioOut,
    output logic [SAMPLE_W-1:0]          oLeft,
    output logic [SAMPLE_W-1:0]          oRight,
    output logic [NUM_CH-1:0]            oActive
);

    localparam int MIX_W = SAMPLE_W + 4;
    localparam logic signed [MIX_W-1:0] AMP_POS = MIX_W'(AMPLITUDE);
    localparam logic signed [MIX_W-1:0] AMP_NEG = -AMP_POS;
    localparam logic signed [MIX_W-1:0] SAT_MAX = {{5{1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] SAT_MIN = {{5{1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic                         xfer_s;
    logic [NUM_CH-1:0]            active_r;
    logic [NUM_CH-1:0]            phase_r;
    logic [PERIOD_W-1:0]          cnt_r    [NUM_CH];
    logic [PERIOD_W-1:0]          half_r   [NUM_CH];
    logic [DUR_W-1:0]             remain_r [NUM_CH];
    logic signed [MIX_W-1:0]      mix_s;
    logic signed [MIX_W-1:0]      mix_r;
    logic                         found_s;

    // Square-wave level of one channel; a zero half-period stays silent.
    function automatic logic signed [MIX_W-1:0] tone_level(
        input logic act,
        input logic phase,
        input logic [PERIOD_W-1:0] half
    );
        if (act && (half != PERIOD_W'(0))) begin
            return phase ? AMP_NEG : AMP_POS;
        end else begin
            return MIX_W'(0);
        end
    endfunction

    // Widened signed add of mic and mix, clamped to the sample range.
    function automatic logic [SAMPLE_W-1:0] sat_add(
        input logic [SAMPLE_W-1:0]      mic,
        input logic signed [MIX_W-1:0]  mix
    );
        logic signed [MIX_W-1:0] sum;
        sum = $signed({{4{mic[SAMPLE_W-1]}}, mic}) + mix;
        if (sum > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end else if (sum < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end else begin
            return sum[SAMPLE_W-1:0];
        end
    endfunction

    assign xfer_s         = iAudioInAvailable & iAudioOutAllowed;
    assign oReadAudioIn   = xfer_s & iResetn;
    assign oWriteAudioOut = xfer_s & iResetn;
    assign oActive        = active_r;

    // Per-channel trigger latch, phase counter and duration countdown.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            active_r <= NUM_CH'(0);
            phase_r  <= NUM_CH'(0);
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k]    <= PERIOD_W'(0);
                half_r[k]   <= PERIOD_W'(0);
                remain_r[k] <= DUR_W'(0);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                // A trigger overrides the final decrement landing in the same cycle.
                if (iTrigger[k] && (iDuration[k*DUR_W +: DUR_W] != DUR_W'(0))) begin
                    active_r[k] <= 1'b1;
                    phase_r[k]  <= 1'b0;
                    cnt_r[k]    <= PERIOD_W'(0);
                    half_r[k]   <= iHalfPeriod[k*PERIOD_W +: PERIOD_W];
                    remain_r[k] <= iDuration[k*DUR_W +: DUR_W];
                end else if (active_r[k]) begin
                    if (cnt_r[k] == (half_r[k] - PERIOD_W'(1))) begin
                        cnt_r[k]   <= PERIOD_W'(0);
                        phase_r[k] <= ~phase_r[k];
                    end else begin
                        cnt_r[k] <= cnt_r[k] + PERIOD_W'(1);
                    end
                    if (xfer_s) begin
                        remain_r[k] <= remain_r[k] - DUR_W'(1);
                        if (remain_r[k] == DUR_W'(1)) begin
                            active_r[k] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Mix: sum of all channels, or only the lowest-index active one; mute wins.
    always_comb begin
        mix_s   = MIX_W'(0);
        found_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!iPriorityMode || !found_s) begin
                mix_s = mix_s + tone_level(active_r[k], phase_r[k], half_r[k]);
            end else begin
                mix_s = mix_s;
            end
            if (active_r[k]) begin
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (iMute) begin
            mix_s = MIX_W'(0);
        end else begin
            mix_s = mix_s;
        end
    end

    // Registered mix term feeding the saturating output adders.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            mix_r <= MIX_W'(0);
        end else begin
            mix_r <= mix_s;
        end
    end

    assign oLeft  = sat_add(iMicLeft,  mix_r);
    assign oRight = sat_add(iMicRight, mix_r);

endmodule
